// File: rtl/dot_product_ctrl.sv
// Sequencer for the dotProduct datapath: streams element pairs out of two mem2
// vector memories, accumulates their products and hands the sum out on a valid/ready port.
// Optional feature macro: DOT_SATURATE_EN (saturating accumulator with sticky overflow).
module dot_product_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  busy,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  overflow
);

    localparam int PROD_WIDTH = 2*DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q, idx_q, idx_inc;
    logic                  vld_pipe;
    logic [ACC_WIDTH-1:0]  acc_q, acc_nxt;
    logic                  ovf_q, ovf_nxt;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]    sum;
    logic                  accept, last_rd;

    assign accept  = (state == IDLE) && start;
    assign idx_inc = idx_q + IDX_ONE;
    assign last_rd = (idx_inc == len_q);

    assign rd_en   = (state == READ);
    assign rd_addr = rd_en ? (base_q + idx_q[ADDR_WIDTH-1:0]) : '0;
    assign busy    = (state != IDLE);
    assign overflow = ovf_q;

    // One extra sum bit exposes the carry out of the accumulator.
    assign prod = PROD_WIDTH'(a_data) * PROD_WIDTH'(b_data);
    assign sum  = {1'b0, acc_q} + (ACC_WIDTH+1)'(prod);

`ifdef DOT_SATURATE_EN
    always_comb begin
        acc_nxt = sum[ACC_WIDTH-1:0];
        ovf_nxt = ovf_q;
        if (sum[ACC_WIDTH] || ovf_q) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
        end
    end
`else
    always_comb begin
        acc_nxt = sum[ACC_WIDTH-1:0];
        ovf_nxt = 1'b0;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (length == '0) ? DONE : READ;
            READ:  if (last_rd) state_nxt = DRAIN;
            DRAIN: state_nxt = DONE;
            DONE:  if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            vld_pipe     <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            // mem2 answers one cycle after the read, so the read strobe is delayed once
            vld_pipe <= rd_en;
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
                idx_q  <= '0;
                acc_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (state == READ) idx_q <= idx_inc;
                if (vld_pipe) begin
                    acc_q <= acc_nxt;
                    ovf_q <= ovf_nxt;
                end
            end
            if (accept && (length == '0)) begin
                result       <= '0;
                result_valid <= 1'b1;
            end else if (state == DRAIN) begin
                // the final product lands on the same edge that publishes the result
                result       <= vld_pipe ? acc_nxt : acc_q;
                result_valid <= 1'b1;
            end else if ((state == DONE) && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl with a 16-bit accumulator and a
// behavioural mem2 pair; expected addresses/results are queued at job issue.
module tb_dot_product_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b1;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    logic [AW-1:0] exp_addr [$];
    logic [CW-1:0] exp_res  [$];
    logic          exp_ovf  [$];

    always #5 clk = ~clk;

    dot_product_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data), .busy(busy),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .overflow(overflow)
    );

    // mem2 model: one-cycle registered read
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    always @(negedge clk) begin
        if (rd_en) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
                n_fail++;
                $display("FAIL rd_addr: unexpected read at addr %0d", rd_addr);
            end else begin
                logic [AW-1:0] ea;
                ea = exp_addr.pop_front();
                if (rd_addr !== ea) begin
                    n_fail++;
                    $display("FAIL rd_addr: got %0d expected %0d", rd_addr, ea);
                end
            end
        end
        if (result_valid && result_ready) begin
            n_checks++;
            if (exp_res.size() == 0) begin
                n_fail++;
                $display("FAIL result: unexpected result %0h", result);
            end else begin
                logic [CW-1:0] er;
                logic          eo;
                er = exp_res.pop_front();
                eo = exp_ovf.pop_front();
                if (result !== er || overflow !== eo) begin
                    n_fail++;
                    $display("FAIL result: got %0h ovf %0b expected %0h ovf %0b", result, overflow, er, eo);
                end
            end
        end
    end

    // Queue expectations from the memory contents, then pulse start; returns in cycle E+1.
    task automatic issue(input int base, input int len);
        longint s = 0;
        logic   o = 1'b0;
        for (int i = 0; i < len; i++) begin
            int ad;
            ad = (base + i) % 16;
            exp_addr.push_back(ad[AW-1:0]);
            s += longint'(mem_a[ad]) * longint'(mem_b[ad]);
`ifdef DOT_SATURATE_EN
            if (s > 65535) begin s = 65535; o = 1'b1; end
`else
            s = s % 65536;
`endif
        end
        exp_res.push_back(s[CW-1:0]);
        exp_ovf.push_back(o);
        @(posedge clk); #1;
        base_addr = base[AW-1:0];
        length    = len[AW:0];
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 50) begin @(negedge clk); t++; end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, t);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr, busy, result, result_valid, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rd_en=%0b addr=%0d busy=%0b res=%0h vld=%0b ovf=%0b expected all 0",
                     rd_en, rd_addr, busy, result, result_valid, overflow);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int first = -1;
        for (int i = 0; i < 4; i++) begin mem_a[i] = DW'(i + 1); mem_b[i] = DW'(i + 5); end
        issue(0, 4);
        n_checks++;
        if (exp_res[0] !== 16'd70) begin n_fail++; $display("FAIL basic_model: got %0d expected 70", exp_res[0]); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (rd_en !== (c <= 4)) begin
                n_fail++;
                $display("FAIL basic_rd_en: cycle E+%0d got %0b expected %0b", c, rd_en, (c <= 4));
            end
            if (result_valid && first < 0) first = c;
        end
        n_checks++;
        if (first != 6) begin n_fail++; $display("FAIL basic_latency: valid at E+%0d expected E+6", first); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy %0b expected 0", busy); end
    endtask

    task automatic test_reset_mid_job();
        issue(0, 4);
        @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_job: got rd_en=%0b busy=%0b vld=%0b res=%0h expected 0 0 0 0",
                     rd_en, busy, result_valid, result);
        end
        exp_addr.delete(); exp_res.delete(); exp_ovf.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_abort: got vld=%0b busy=%0b expected 0 0", result_valid, busy);
            end
        end
    endtask

    task automatic test_wrap();
        int idx [4] = '{14, 15, 0, 1};
        foreach (idx[i]) begin
            mem_a[idx[i]] = DW'($urandom_range(0, 63));
            mem_b[idx[i]] = DW'($urandom_range(0, 63));
        end
        issue(14, 4);
        wait_idle();
        n_checks++;
        if (exp_addr.size() != 0) begin n_fail++; $display("FAIL wrap_reads: %0d reads missing expected 0", exp_addr.size()); end
    endtask

    task automatic test_zero_len();
        int first = -1;
        issue(5, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (rd_en !== 1'b0) begin n_fail++; $display("FAIL zero_rd_en: cycle E+%0d got %0b expected 0", c, rd_en); end
            if (result_valid && first < 0) first = c;
        end
        n_checks++;
        if (first != 1) begin n_fail++; $display("FAIL zero_latency: valid at E+%0d expected E+1", first); end
    endtask

    task automatic test_backpressure();
        int t = 0;
        logic [CW-1:0] held;
        mem_a[3] = 8'd9;  mem_b[3] = 8'd11;
        mem_a[4] = 8'd20; mem_b[4] = 8'd3;
        result_ready = 1'b0;
        issue(3, 2);
        while (!result_valid && t < 20) begin @(negedge clk); t++; end
        held = exp_res[0];
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin @(posedge clk); #1 start = 1'b1; base_addr = 4'd0; length = 5'd3; end
            if (c == 2) begin @(posedge clk); #1 start = 1'b0; end
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || result !== held) begin
                n_fail++;
                $display("FAIL hold: got vld=%0b busy=%0b res=%0h expected 1 1 %0h", result_valid, busy, result, held);
            end
        end
        @(posedge clk); #1 result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== held) begin
            n_fail++;
            $display("FAIL release: got busy=%0b vld=%0b res=%0h expected 0 0 %0h", busy, result_valid, result, held);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_ignored: busy %0b expected 0", busy); end
    endtask

    task automatic test_overflow();
        int t = 0;
        mem_a[0] = 8'hFF; mem_b[0] = 8'hFF;
        mem_a[1] = 8'hFF; mem_b[1] = 8'hFF;
        issue(0, 2);
        while (!result_valid && t < 20) begin @(negedge clk); t++; end
        n_checks++;
`ifdef DOT_SATURATE_EN
        if (result !== 16'hFFFF || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow: got %0h ovf %0b expected ffff 1", result, overflow);
        end
`else
        if (result !== 16'hFC02 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow: got %0h ovf %0b expected fc02 0", result, overflow);
        end
`endif
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 6; i < 9; i++) begin mem_a[i] = DW'(i); mem_b[i] = DW'(2 * i); end
        issue(6, 3);
        wait_idle();
        issue(7, 2);
        wait_idle();
        @(negedge clk);
        n_checks++;
        if (exp_res.size() != 0 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results %0d reads left expected 0 0", exp_res.size(), exp_addr.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        test_reset();
        test_basic();
        test_reset_mid_job();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
